// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  // Legacy-compatible state encodings, wrapped in an enum for readability
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access size codes
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Request captured from EX/MEM when the access is accepted
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  // Byte for lb/lbu, half for lh/lhu, everything else (incl. reserved) is a word
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: access_size = SZ_BYTE;
      F3_LH, F3_LHU: access_size = SZ_HALF;
      default:       access_size = SZ_WORD;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given word offset
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (access_size(f3))
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// EX/MEM-side request bus and MEM-stage response bus of the data-memory responder.
// Latency: n/a (signal bundle only).
// Backpressure: stall_o freezes the master while an access is in flight.
interface dmem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  funct3_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        stall_o;
  logic        misalign_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i, funct3_i,
    input  rdata_o, rvalid_o, stall_o, misalign_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i, funct3_i,
    output rdata_o, rvalid_o, stall_o, misalign_o
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte write enables and a registered read port.
// Latency: write lands on the enabling edge; read word appears after the enabling edge.
// Backpressure: none; the caller sequences accesses.
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and registered read; contents are deliberately never reset
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder; DMEM_BYTE_EN enables byte/half accesses (else word-only).
// Latency: LATENCY stall cycles then one DONE cycle with rvalid_o (LATENCY+1 total).
// Backpressure: stall_o holds EX/MEM and earlier stages until the DONE cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  req_t          req_q;
  req_t          req_live;
  req_t          acc;
  logic          req;
  logic          fire;
  logic          mis;
  logic          mis_q;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rd_word;
  logic          ld_zero_q;
  logic [31:0]   ext;

  assign req      = bus.MemRead_i | bus.MemWrite_i;
  assign req_live = '{wr: bus.MemWrite_i, addr: bus.addr_i, wdata: bus.wdata_i, funct3: bus.funct3_i};
  // With LATENCY=1 the access happens on the accepting edge, so it must use live inputs
  assign acc      = (state_q == IDLE) ? req_live : req_q;
  assign cnt_nxt  = cnt_q - 1'b1;
  assign fire     = ((state_q == IDLE) && req && (LATENCY == 1)) ||
                    ((state_q == BUSY) && (cnt_nxt == '0));

`ifdef DMEM_BYTE_EN
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;
  logic [31:0] lane;

  // Alignment, lane mask and store-data replication for sized accesses
  always_comb begin
    mis = 1'b0;
    case (access_size(acc.funct3))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = acc.addr[0];
      default: mis = |acc.addr[1:0];
    endcase
    be = lane_mask(acc.funct3, acc.addr[1:0]);
    case (access_size(acc.funct3))
      SZ_BYTE: wdata_lane = {4{acc.wdata[7:0]}};
      SZ_HALF: wdata_lane = {2{acc.wdata[15:0]}};
      default: wdata_lane = acc.wdata;
    endcase
  end

  // Remember how the last completed load must be extended
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_f3_q  <= F3_LW;
      ld_off_q <= 2'b00;
    end else if (fire && !acc.wr) begin
      ld_f3_q  <= acc.funct3;
      ld_off_q <= acc.addr[1:0];
    end
  end

  // Select the lane of the registered word and sign/zero extend it
  always_comb begin
    lane = rd_word >> {ld_off_q, 3'b000};
    ext  = rd_word;
    case (access_size(ld_f3_q))
      SZ_BYTE: ext = ld_f3_q[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: ext = ld_f3_q[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ext = rd_word;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{acc.addr[31:AW+2], lane[31:16]};
`else
  assign mis        = |acc.addr[1:0];
  assign be         = 4'hF;
  assign wdata_lane = acc.wdata;
  assign ext        = rd_word;

  logic unused_bits;
  assign unused_bits = ^{acc.addr[31:AW+2], acc.funct3};
`endif

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i (clk_i),
    .we    (fire && acc.wr && !mis && !rst_i),
    .be    (be),
    .re    (fire && !acc.wr && !rst_i),
    .idx   (acc.addr[AW+1:2]),
    .wdata (wdata_lane),
    .rdata (rd_word)
  );

  // Request FSM: accept in IDLE, count down in BUSY, one DONE cycle, back to IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            req_q   <= req_live;
            cnt_q   <= CNT_LOAD;
            mis_q   <= mis;
            state_q <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt == '0) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Misaligned loads read back as zero; stores leave the last load result alone
  always_ff @(posedge clk_i) begin
    if (rst_i) ld_zero_q <= 1'b1;
    else if (fire && !acc.wr) ld_zero_q <= mis;
  end

  assign bus.rdata_o    = ld_zero_q ? 32'h0 : ext;
  assign bus.rvalid_o   = (state_q == DONE);
  assign bus.misalign_o = (state_q == DONE) && mis_q;
  assign bus.stall_o    = ((state_q == IDLE) && req) || (state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a byte-array memory model.
// Latency: expects LAT stall cycles then one completion cycle per memory op.
// Backpressure: requests are held until their completion cycle, as a stalled pipeline would.
module tb_dmem_responder;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int NBYTE = 4 * DEPTH;

  logic clk_i = 1'b0;
  logic rst_i;
  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_rvalid, exp_mis;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;
  logic [7:0]  mem_m [NBYTE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, act, want);
    end
  endtask

  task automatic set_exp(input logic st, input logic rv, input logic mi, input logic [31:0] rd);
    exp_stall  = st;
    exp_rvalid = rv;
    exp_mis    = mi;
    exp_rdata  = rd;
  endtask

  // One compare process: every cycle the outputs are checked against the expectation
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall_o",    {31'b0, bus.stall_o},    {31'b0, exp_stall});
      check("rvalid_o",   {31'b0, bus.rvalid_o},   {31'b0, exp_rvalid});
      check("misalign_o", {31'b0, bus.misalign_o}, {31'b0, exp_mis});
      check("rdata_o",    bus.rdata_o,             exp_rdata);
    end
  end

  function automatic int op_size(input logic [2:0] f3);
`ifdef DMEM_BYTE_EN
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
`else
    return 4;
`endif
  endfunction

  function automatic bit op_signed(input logic [2:0] f3);
`ifdef DMEM_BYTE_EN
    return (f3 == 3'b000 || f3 == 3'b001);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      bus.MemRead_i  = 1'b0;
      bus.MemWrite_i = 1'b0;
      bus.addr_i     = $urandom;
      bus.wdata_i    = $urandom;
      bus.funct3_i   = 3'($urandom);
      set_exp(1'b0, 1'b0, 1'b0, last_rdata);
    end
  endtask

  // One memory instruction held in MEM: LAT stalled cycles, then the completion cycle
  task automatic mem_op(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] got);
    int          size;
    int          base;
    bit          mis;
    logic [31:0] val;
    size = op_size(f3);
    mis  = (addr % size) != 0;
    base = int'(addr % NBYTE);
    @(posedge clk_i); #1;
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = addr;
    bus.wdata_i    = wdata;
    bus.funct3_i   = f3;
    set_exp(1'b1, 1'b0, 1'b0, last_rdata);
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk_i); #1;
      bus.addr_i   = $urandom;
      bus.wdata_i  = $urandom;
      bus.funct3_i = 3'($urandom);
    end
    @(posedge clk_i); #1;
    bus.addr_i   = addr;
    bus.wdata_i  = wdata;
    bus.funct3_i = f3;
    if (wr) begin
      if (!mis) for (int b = 0; b < size; b++) mem_m[base + b] = wdata[8*b +: 8];
    end else begin
      val = 32'h0;
      if (!mis) begin
        for (int b = 0; b < size; b++) val[8*b +: 8] = mem_m[base + b];
        if (op_signed(f3) && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
      end
      last_rdata = val;
    end
    set_exp(1'b0, 1'b1, mis, last_rdata);
    @(negedge clk_i);
    got = bus.rdata_o;
  endtask

  logic [31:0] got;

  initial begin
    rst_i          = 1'b1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = 32'h0;
    bus.wdata_i    = 32'h0;
    bus.funct3_i   = 3'b010;
    last_rdata     = 32'h0;
    @(posedge clk_i); #1;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0);
    chk_en = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Give every word a known value so later loads are fully predictable
    for (int w = 0; w < DEPTH; w++) mem_op(1'b1, 1'b0, 32'(4 * w), $urandom, 3'b010, got);

    mem_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010, got);
    mem_op(1'b0, 1'b1, 32'h10, 32'h0, 3'b010, got);
    check("pin_lw_10", got, 32'hDEADBEEF);
`ifdef DMEM_BYTE_EN
    mem_op(1'b0, 1'b1, 32'h13, 32'h0, 3'b000, got);
    check("pin_lb_13", got, 32'hFFFFFFDE);
    mem_op(1'b0, 1'b1, 32'h13, 32'h0, 3'b100, got);
    check("pin_lbu_13", got, 32'h000000DE);
    mem_op(1'b0, 1'b1, 32'h12, 32'h0, 3'b001, got);
    check("pin_lh_12", got, 32'hFFFFDEAD);
    mem_op(1'b0, 1'b1, 32'h10, 32'h0, 3'b101, got);
    check("pin_lhu_10", got, 32'h0000BEEF);
    mem_op(1'b1, 1'b0, 32'h11, 32'h0000005A, 3'b000, got);
    mem_op(1'b0, 1'b1, 32'h10, 32'h0, 3'b010, got);
    check("pin_sb_11", got, 32'hDEAD5AEF);
`else
    mem_op(1'b0, 1'b1, 32'h13, 32'h0, 3'b000, got);
    check("pin_word_only_mis", got, 32'h0);
    mem_op(1'b0, 1'b1, 32'h10, 32'h0, 3'b000, got);
    check("pin_f3_ignored", got, 32'hDEADBEEF);
    mem_op(1'b1, 1'b0, 32'h10, 32'h0000005A, 3'b000, got);
    mem_op(1'b0, 1'b1, 32'h10, 32'h0, 3'b010, got);
    check("pin_full_word_store", got, 32'h0000005A);
`endif
    mem_op(1'b1, 1'b0, 32'h04, 32'h0BADF00D, 3'b010, got);
    mem_op(1'b0, 1'b1, 32'h06, 32'h0, 3'b010, got);
    check("pin_mis_lw_06", got, 32'h0);
    mem_op(1'b1, 1'b0, 32'h06, 32'h12345678, 3'b010, got);
    mem_op(1'b0, 1'b1, 32'h04, 32'h0, 3'b010, got);
    check("pin_mis_sw_nowrite", got, 32'h0BADF00D);

    // Reset in the first BUSY cycle of a store discards it
    mem_op(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 3'b010, got);
    @(posedge clk_i); #1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b1;
    bus.addr_i     = 32'h20;
    bus.wdata_i    = 32'h11111111;
    bus.funct3_i   = 3'b010;
    set_exp(1'b1, 1'b0, 1'b0, last_rdata);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, last_rdata);
    @(posedge clk_i); #1;
    rst_i          = 1'b0;
    bus.MemWrite_i = 1'b0;
    last_rdata     = 32'h0;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0);
    mem_op(1'b0, 1'b1, 32'h20, 32'h0, 3'b010, got);
    check("pin_rst_nowrite", got, 32'hCAFEF00D);
    mem_op(1'b0, 1'b1, 32'(32'h20 + NBYTE), 32'h0, 3'b010, got);
    check("pin_alias_rd", got, 32'hCAFEF00D);
    mem_op(1'b1, 1'b0, 32'(32'h20 + 2 * NBYTE), 32'h600DCAFE, 3'b010, got);
    mem_op(1'b0, 1'b1, 32'h20, 32'h0, 3'b010, got);
    check("pin_alias_wr", got, 32'h600DCAFE);

    // Random mix of idle cycles, loads, stores and simultaneous read/write
    for (int n = 0; n < 400; n++) begin
      int          mode;
      logic [2:0]  f3;
      logic [31:0] a;
      idle($urandom_range(0, 2));
      mode = $urandom_range(0, 2);
      a    = $urandom_range(0, 255);
      if (mode == 0) begin
        f3 = 3'($urandom);
        mem_op(1'b0, 1'b1, a, $urandom, f3, got);
      end else begin
        f3 = 3'($urandom_range(0, 3));
        mem_op(1'b1, mode == 2, a, $urandom, f3, got);
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the MEM stage of the pipelined RISC-V core. It sits on the far side of the EX/MEM pipeline register and consumes its outputs: MemRead, MemWrite, the ALU result as address, and the forwarded rs2 value as write data. It performs each load or store over a configurable multi-cycle latency and stalls the pipeline while the access is in flight. Load data is returned registered and extended, ready for the MEM/WB register.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two.
- LATENCY, 2, access cycles before completion; must be at least 1.

Ports. One clock; reset is synchronous and active-high.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- MemRead_i  input  1  load request from EX/MEM.
- MemWrite_i  input  1  store request from EX/MEM.
- addr_i  input  32  byte address (ALU result).
- wdata_i  input  32  store data (forwarded rs2).
- funct3_i  input  3  access size and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- rdata_o  output  32  extended load data; valid while rvalid_o=1.
- rvalid_o  output  1  access-complete strobe, asserted for one cycle.
- stall_o  output  1  hold request; EX/MEM and earlier stages freeze while high.
- misalign_o  output  1  misaligned-access flag, asserted for one cycle with rvalid_o.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - req = MemRead_i | MemWrite_i.
  - If req: latch addr, wdata, funct3 and op (write wins when both are high). Load counter with LATENCY-1. Go to BUSY, or to DONE when LATENCY=1.
  - If no req: stay in IDLE.
- **BUSY**: decrement counter each cycle. At counter=0, perform the access and go to DONE.
  - Store: byte-masked write into the array on that edge.
  - Load: read, extend, and register into rdata_o on that edge.
- **DONE**: rvalid_o=1, stall_o=0, and go to IDLE. The held EX/MEM request is not re-accepted: the pipeline advances at the end of DONE.
- stall_o = (IDLE & req) | BUSY. It is combinational from the inputs in IDLE.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap.
- Misaligned access: half-word with addr[0]=1, or word with addr[1:0]≠0.
  - No array write.
  - rdata_o=0.
  - misalign_o=1 during DONE.
- Store: rdata_o keeps its previous value and rvalid_o still pulses.
- Load extension:
  - lb/lh sign-extend from bit 7/15 of the selected lane.
  - lbu/lhu zero-extend.
  - Reserved funct3 values are treated as lw.

## Timing
- Reset values: state=IDLE, counter=0, rdata_o=0, rvalid_o=0, misalign_o=0. stall_o=0 unless a req is present.
- Array contents are not reset.
- A memory instruction occupies MEM for exactly LATENCY+1 cycles:
  - stall_o high for LATENCY cycles.
  - One DONE cycle.
- Non-memory instructions: zero stall, no rvalid_o.
- Load data appears in rdata_o on the edge entering DONE and holds until the next completed load.
- Back-to-back memory ops: the IDLE cycle following DONE samples the next request, with no bubble beyond DONE.
- rst_i during BUSY: return to IDLE next edge; any pending store is discarded; outputs take reset values.
- rst_i has priority over every transition, including the array write edge.
- Input changes during BUSY/DONE are ignored; only latched values are used.

## Configuration
- DMEM_BYTE_EN defined:
  - Full funct3 support.
  - Byte/half stores use a 4-bit lane mask: data replicated, mask from addr[1:0].
- DMEM_BYTE_EN undefined:
  - funct3_i is ignored; every access is a full word.
  - Any addr[1:0]≠0 is misaligned.
  - The array has a single 32-bit write enable.

## Structure
- Shared package dmem_pkg:
  - state enum (IDLE/BUSY/DONE).
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Lane-mask function.
- Sub-module dmem_array:
  - DEPTH_WORDS×32 storage.
  - Synchronous write with 4-bit byte enable.
  - Synchronous read.
- Top level holds the FSM, counter, alignment check and extension logic.

## Test plan
- Reset, then sw 0xDEADBEEF to 0x10 with LATENCY=2 -> stall_o high for 2 cycles, rvalid_o in the 3rd cycle. A following lw from 0x10 returns 0xDEADBEEF.
- After that store, lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- sb 0x5A to 0x11 over 0xDEADBEEF -> lw 0x10 returns 0xDEAD5AEF.
- lw from 0x06 -> misalign_o=1 and rvalid_o=1 in DONE, rdata_o=0. A sw 0x12345678 to 0x06 leaves memory unchanged.
- Assert rst_i in the first BUSY cycle of sw 0x11111111 to 0x20 -> no write, and lw 0x20 returns the prior value. Address 0x20+4*DEPTH_WORDS aliases to 0x20.
- Alternate non-memory and memory ops -> non-memory cycles give stall_o=0. Each memory op gives exactly LATENCY stall cycles. No request is accepted twice.
